// File: rtl/atan2_pkg.sv
// Shared constants and types for the atan2 core and the requester arbiter in front of it.
package atan2_pkg;

  localparam int unsigned ATAN2_WIDTH   = 16;
  localparam int unsigned ATAN2_LATENCY = 18;
  localparam int unsigned ATAN2_SCALE   = 8192;  // LSB per radian on the result
  localparam int unsigned ATAN2_ZFRAC   = 4;     // extra angle fraction bits inside the core
  localparam int          ATAN2_PI_Z    = 411775;  // pi * ATAN2_SCALE * 2**ATAN2_ZFRAC

  typedef struct packed {
    logic       valid;
    logic [3:0] channel;
  } atan2_tag_t;

  // atan(2**-i) in units of 1 / (ATAN2_SCALE * 2**ATAN2_ZFRAC) rad
  function automatic int atan2_step_angle(input int i);
    case (i)
      0:       return 102944;
      1:       return 60771;
      2:       return 32110;
      3:       return 16299;
      4:       return 8181;
      5:       return 4095;
      6:       return 2048;
      7:       return 1024;
      default: return (i <= 17) ? (1 << (17 - i)) : 0;
    endcase
  endfunction

endpackage

// File: rtl/atan2.sv
// Pipelined CORDIC atan2(y, x): result in 8192 LSB/rad, exactly LATENCY registers deep, no reset.
module atan2
  import atan2_pkg::*;
#(
  parameter int unsigned WIDTH   = ATAN2_WIDTH,
  parameter int unsigned LATENCY = ATAN2_LATENCY
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] sink_x,
  input  logic [WIDTH-1:0] sink_y,
  output logic [WIDTH-1:0] source
);

  localparam int unsigned NIt   = LATENCY - 2;
  localparam int unsigned XFrac = 8;
  localparam int unsigned IW    = WIDTH + XFrac + 2;  // two guard bits cover the CORDIC gain
  localparam int unsigned ZW    = WIDTH + ATAN2_ZFRAC + 1;
  localparam logic signed [ZW-1:0] PiZ = ZW'(ATAN2_PI_Z);

  logic signed [IW-1:0] x_in, y_in;
  logic signed [IW-1:0] x_q [NIt+1];
  logic signed [IW-1:0] y_q [NIt+1];
  logic signed [ZW-1:0] z_q [NIt+1];
  logic [WIDTH-1:0]     source_q;

  assign x_in = {{2{sink_x[WIDTH-1]}}, sink_x, {XFrac{1'b0}}};
  assign y_in = {{2{sink_y[WIDTH-1]}}, sink_y, {XFrac{1'b0}}};

  always_ff @(posedge clk) begin
    // Left half-plane: rotate by pi so the vectoring stages only see x >= 0.
    if (x_in[IW-1]) begin
      x_q[0] <= -x_in;
      y_q[0] <= -y_in;
      z_q[0] <= y_in[IW-1] ? -PiZ : PiZ;
    end else begin
      x_q[0] <= x_in;
      y_q[0] <= y_in;
      z_q[0] <= '0;
    end
    for (int i = 0; i < int'(NIt); i++) begin
      if (y_q[i][IW-1]) begin
        x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
        y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
        z_q[i+1] <= z_q[i] - ZW'(atan2_step_angle(i));
      end else begin
        x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
        y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
        z_q[i+1] <= z_q[i] + ZW'(atan2_step_angle(i));
      end
    end
    source_q <= WIDTH'((z_q[NIt] + ZW'(1 << (ATAN2_ZFRAC - 1))) >>> ATAN2_ZFRAC);
  end

  assign source = source_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx,
  output logic            any
);

  logic [IdxW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IdxW'((32'(ptr) + off) % N);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/atan2_arbiter.sv
// Round-robin sharing of one atan2 core between N_REQ requesters, results tagged by channel.
// Define ATAN2_ARB_STATS_EN to add per-channel grant counters and an idle-cycle counter.
module atan2_arbiter
  import atan2_pkg::*;
#(
  parameter  int unsigned WIDTH   = ATAN2_WIDTH,
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned LATENCY = ATAN2_LATENCY,
  localparam int unsigned CW      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0][WIDTH-1:0] sink_x,
  input  logic [N_REQ-1:0][WIDTH-1:0] sink_y,
  input  logic [N_REQ-1:0]            sink_valid,
  output logic [N_REQ-1:0]            sink_ready,
  output logic [WIDTH-1:0]            source,
  output logic                        source_valid,
`ifdef ATAN2_ARB_STATS_EN
  output logic [N_REQ-1:0][31:0]      grant_count,
  output logic [31:0]                 idle_count,
`endif
  output logic [CW-1:0]               source_channel
);

  logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] grant;
  logic [CW-1:0]    grant_idx;
  logic             grant_any, xfer;

  logic [WIDTH-1:0] issue_x_q, issue_x_d, issue_y_q, issue_y_d;
  atan2_tag_t       issue_tag_q, issue_tag_d;
  atan2_tag_t       tag_q [LATENCY];
  logic [WIDTH-1:0] core_phase;

  logic [WIDTH-1:0] source_q;
  logic             source_valid_q;
  logic [CW-1:0]    source_channel_q;

  rr_arbiter #(
    .N(N_REQ)
  ) u_rr_arbiter (
    .req      (sink_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (grant_any)
  );

  assign sink_ready = reset_n ? grant : '0;
  assign xfer       = reset_n & grant_any;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    issue_x_d   = '0;
    issue_y_d   = '0;
    issue_tag_d = '0;
    if (xfer) begin
      rr_ptr_d            = (grant_idx == CW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      issue_x_d           = sink_x[grant_idx];
      issue_y_d           = sink_y[grant_idx];
      issue_tag_d.valid   = 1'b1;
      issue_tag_d.channel = 4'(grant_idx);
    end
  end

  atan2 #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_atan2 (
    .clk   (clk),
    .sink_x(issue_x_q),
    .sink_y(issue_y_q),
    .source(core_phase)
  );

  // The core has no reset, so clearing the tags is what suppresses stale results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q         <= '0;
      issue_x_q        <= '0;
      issue_y_q        <= '0;
      issue_tag_q      <= '0;
      for (int i = 0; i < int'(LATENCY); i++) tag_q[i] <= '0;
      source_q         <= '0;
      source_valid_q   <= 1'b0;
      source_channel_q <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      issue_x_q        <= issue_x_d;
      issue_y_q        <= issue_y_d;
      issue_tag_q      <= issue_tag_d;
      tag_q[0]         <= issue_tag_q;
      for (int i = 1; i < int'(LATENCY); i++) tag_q[i] <= tag_q[i-1];
      source_q         <= core_phase;
      source_valid_q   <= tag_q[LATENCY-1].valid;
      source_channel_q <= tag_q[LATENCY-1].channel[CW-1:0];
    end
  end

  assign source         = source_q;
  assign source_valid   = source_valid_q;
  assign source_channel = source_channel_q;

`ifdef ATAN2_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] grant_count_q;
  logic [31:0]            idle_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_count_q <= '0;
      idle_count_q  <= '0;
    end else if (xfer) begin
      if (grant_count_q[grant_idx] != '1) begin
        grant_count_q[grant_idx] <= grant_count_q[grant_idx] + 32'd1;
      end
    end else if (idle_count_q != '1) begin
      idle_count_q <= idle_count_q + 32'd1;
    end
  end

  assign grant_count = grant_count_q;
  assign idle_count  = idle_count_q;
`endif

endmodule

// File: tb/tb_atan2_arbiter.sv
// Scoreboard bench for atan2_arbiter: model-predicted grants, $atan2 reference, fixed latency.
module tb_atan2_arbiter;

  localparam int  W       = 16;
  localparam int  N       = 4;
  localparam int  L       = 18;
  localparam real TwoPi8k = 51471.854;

  logic                clk     = 1'b0;
  logic                reset_n = 1'b0;
  logic [N-1:0][W-1:0] sink_x  = '0;
  logic [N-1:0][W-1:0] sink_y  = '0;
  logic [N-1:0]        sink_valid = '0;
  logic [N-1:0]        sink_ready;
  logic [W-1:0]        source;
  logic                source_valid;
  logic [1:0]          source_channel;
`ifdef ATAN2_ARB_STATS_EN
  logic [N-1:0][31:0]  grant_count;
  logic [31:0]         idle_count;
`endif

  typedef struct {
    int ch;
    int x;
    int y;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;
  int   ptr    = 0;
  int   idle_n = 0;
  int   gcnt [N];

  atan2_arbiter #(
    .WIDTH  (W),
    .N_REQ  (N),
    .LATENCY(L)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sink_x        (sink_x),
    .sink_y        (sink_y),
    .sink_valid    (sink_valid),
    .sink_ready    (sink_ready),
    .source        (source),
    .source_valid  (source_valid),
`ifdef ATAN2_ARB_STATS_EN
    .grant_count   (grant_count),
    .idle_count    (idle_count),
`endif
    .source_channel(source_channel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
  endtask

  // Monitor: a result is due exactly when the oldest scoreboard entry says so.
  always @(negedge clk) begin : monitor
    bit   due;
    exp_t e;
    real  ref_a, d;
    due = (sb.size() > 0) && (sb[0].due == cyc);
    chk(source_valid == due, "valid_timing", int'(source_valid), int'(due));
    if (due) begin
      e = sb.pop_front();
      if (source_valid) begin
        chk(int'(source_channel) == e.ch, "channel", int'(source_channel), e.ch);
        ref_a = $atan2(real'(e.y), real'(e.x)) * 8192.0;
        d = real'($signed(source)) - ref_a;
        if (d > 25736.0) d -= TwoPi8k;
        else if (d < -25736.0) d += TwoPi8k;
        chk(d >= -2.0 && d <= 2.0, "phase", int'($signed(source)), $rtoi(ref_a));
      end
    end
  end

  task automatic set_xy(input int ch, input int x, input int y);
    sink_x[ch] = W'(x);
    sink_y[ch] = W'(y);
  endtask

  task automatic rand_xy(input int ch);
    int x, y;
    x = int'($urandom_range(65535)) - 32768;
    y = int'($urandom_range(65535)) - 32768;
    if (x > -1024 && x < 1024 && y > -1024 && y < 1024) x = (x < 0) ? x - 1024 : x + 1024;
    set_xy(ch, x, y);
  endtask

  task automatic rand_all();
    for (int c = 0; c < N; c++) rand_xy(c);
  endtask

  // One clock: apply inputs, predict the grant, record any transfer, advance past the edge.
  task automatic step(input logic [N-1:0] v, input logic rn);
    int           g;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    sink_valid = v;
    reset_n    = rn;
    #2;
    g       = -1;
    exp_rdy = '0;
    if (rn) begin
      for (int k = 0; k < N; k++) if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk(sink_ready == exp_rdy, "grant", int'(sink_ready), int'(exp_rdy));
    if (!rn) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      ptr    = 0;
      idle_n = 0;
      for (int c = 0; c < N; c++) gcnt[c] = 0;
    end else if (g >= 0) begin
      e.ch  = g;
      e.x   = int'($signed(sink_x[g]));
      e.y   = int'($signed(sink_y[g]));
      e.due = cyc + L + 2;
      sb.push_back(e);
      ptr = (g + 1) % N;
      gcnt[g]++;
    end else begin
      idle_n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int c = 0; c < N; c++) gcnt[c] = 0;
    @(posedge clk);
    #1;
    step(4'hF, 1'b0);
    step(4'hF, 1'b0);
    chk(source == '0, "rst_source", int'(source), 0);
    chk(source_channel == '0, "rst_channel", int'(source_channel), 0);

    // Lone requests with known angles: 0, pi/2, pi.
    set_xy(2, 16384, 0);
    step(4'b0100, 1'b1);
    repeat (25) step(4'b0000, 1'b1);
    set_xy(3, 0, 16384);
    step(4'b1000, 1'b1);
    set_xy(3, -16384, 0);
    step(4'b1000, 1'b1);
    repeat (22) step(4'b0000, 1'b1);

    // All requesters saturating the core.
    for (int i = 0; i < 40; i++) begin
      rand_all();
      step(4'hF, 1'b1);
    end
    repeat (2) step(4'b0000, 1'b1);

    // Pointer after channel 1 and an idle cycle: 3 then 0.
    rand_all();
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b0000, 1'b1);

    // Reset with six pairs in flight.
    for (int i = 0; i < 6; i++) begin
      rand_all();
      step(4'hF, 1'b1);
    end
    step(4'hF, 1'b0);
    repeat (25) step(4'b0000, 1'b1);
    rand_xy(0);
    step(4'b0001, 1'b1);
    repeat (22) step(4'b0000, 1'b1);

    for (int i = 0; i < 300; i++) begin
      rand_all();
      step(N'($urandom_range(15)), 1'b1);
    end
    repeat (22) step(4'b0000, 1'b1);

    // 10 grants to channel 0, 5 to channel 2, 5 idle cycles.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rand_all();
      step((i < 10) ? 4'b0001 : ((i < 15) ? 4'b0100 : 4'b0000), 1'b1);
    end
`ifdef ATAN2_ARB_STATS_EN
    for (int c = 0; c < N; c++) chk(grant_count[c] == 32'(gcnt[c]), "grant_count",
                                    int'(grant_count[c]), gcnt[c]);
    chk(idle_count == 32'(idle_n), "idle_count", int'(idle_count), idle_n);
    step(4'b0000, 1'b0);
    for (int c = 0; c < N; c++) chk(grant_count[c] == '0, "grant_count_rst",
                                    int'(grant_count[c]), 0);
    chk(idle_count == '0, "idle_count_rst", int'(idle_count), 0);
`endif
    repeat (22) step(4'b0000, 1'b1);
    chk(sb.size() == 0, "drain", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/atan2_arbiter.md
# atan2_arbiter

Shares one pipelined `atan2` core between `N_REQ` independent requesters. Each requester offers an (x, y) pair with a valid/ready handshake. A round-robin arbiter admits at most one pair per clock into the core. A tag pipeline, matched to the core latency, returns each phase result marked with the channel that issued it. The block sits between the phase-measurement front ends and the single `atan2` instance; it instantiates that `atan2` instance internally.

## Interface
Parameters:
- `WIDTH`, 16: sample and result width, passed to `atan2`.
- `N_REQ`, 4: number of requesters, 2..16.
- `LATENCY`, 18: `atan2` latency in cycles, from sampling `sink_x`/`sink_y` to the matching `source`.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `sink_x`, in, `N_REQ`×`WIDTH`: signed x, one per requester.
- `sink_y`, in, `N_REQ`×`WIDTH`: signed y, one per requester.
- `sink_valid`, in, `N_REQ`: requester i offers a pair.
- `sink_ready`, out, `N_REQ`: one-hot grant; transfer occurs when valid and ready are both high.
- `source`, out, `WIDTH`: phase result, 8192 LSB/rad, two's complement.
- `source_valid`, out, 1: `source` and `source_channel` are valid this cycle.
- `source_channel`, out, $clog2(`N_REQ`): requester index that owns the result.

## Operation
- Arbiter:
  - Combinational grant: the first i with `sink_valid`[i]=1, searching from `rr_ptr` upward with wrap.
  - `sink_ready` is zero when no requester is valid.
  - At most one bit of `sink_ready` is set; `sink_ready` never depends on other requesters' data.
- Pointer update:
  - On an accepted transfer from channel g, `rr_ptr` becomes (g+1) mod `N_REQ`.
  - With no transfer, `rr_ptr` holds.
- Issue register:
  - On a transfer, register x and y of the granted channel and drive them to the core.
  - Otherwise, load zeros into the issue register.
  - Push tag {valid=1, channel=g} into the tag pipe; push valid=0 when there is no transfer.
- Tag pipe: `LATENCY` stages of {valid, channel}, aligned with the core result.
- Output register:
  - `source` latches the core result every cycle.
  - `source_valid` and `source_channel` come from the tag pipe tail.
- No output backpressure; requesters must consume `source` in the cycle `source_valid` is high.
- Reset values:
  - `rr_ptr`, the issue register, every tag stage, `source`, `source_valid` and `source_channel` reset to 0.
  - Combinationally, `sink_ready` is 0 while `reset_n`=0.
- Reset mid-operation: all in-flight tags are cleared. Core outputs from before reset produce no `source_valid`, even though the core itself has no reset.
- A requester that drops `sink_valid` without a transfer loses nothing; the pointer does not move.

## Timing
- Throughput: one pair per cycle in total; each continuously-valid requester gets at least 1 grant per `N_REQ` cycles.
- Latency: a transfer at edge k produces `source_valid` at edge k+`LATENCY`+1. This is fixed and independent of load.
- Ordering: results leave in grant order.
- Reset: the first grant is possible in the first cycle with `reset_n`=1. That cycle prioritises channel 0.

## Configuration
- `ATAN2_ARB_STATS_EN` defined:
  - Adds output `grant_count`, `N_REQ`×32.
  - Each entry is a saturating counter of accepted transfers per channel, cleared by reset.
  - Also adds output `idle_count`, 32 bits: a saturating count of cycles with no transfer.
- `ATAN2_ARB_STATS_EN` undefined: neither port nor counter exists; the rest of the behaviour is identical.

## Structure
- Package `atan2_pkg` holds:
  - default constants `ATAN2_WIDTH`=16 and `ATAN2_LATENCY`=18;
  - the scale constant 8192 LSB/rad;
  - typedef `atan2_tag_t`, {logic valid; logic [3:0] channel}.
- Sub-module `rr_arbiter`: parameter `N`; inputs `req[N]`, `ptr`; outputs one-hot `grant`, binary `grant_idx`, `any`. It is purely combinational. The pointer register stays in `atan2_arbiter`.

## Test plan
All scenarios use `N_REQ`=4 and `LATENCY`=18.
- Channel 2 alone, x=16384, y=0, accepted at cycle 10 → `source_valid` exactly at cycle 29, `source_channel`=2, `source`=0 ±2. No other `source_valid` occurs.
- Channel 3 alone, x=0, y=16384 → `source`=12868 ±2, `source_channel`=3. Then x=-16384, y=0 → `source`=±25736 ±2.
- All four valid continuously for 40 cycles → grants 0,1,2,3,0,…; results tagged in the same order, one per cycle, starting 19 cycles after the first grant.
- Channel 1 is granted, then only channels 0 and 3 are valid → the next grants are 3, then 0. An idle cycle in between leaves `rr_ptr` at 2.
- Six pairs in flight, then `reset_n` low for 1 cycle → `source_valid` stays 0 for the next 25 cycles. A new request afterwards returns after 19 cycles.
- With `ATAN2_ARB_STATS_EN`: 10 grants to channel 0 and 5 to channel 2 over 20 cycles → `grant_count`={10,0,5,0}, `idle_count`=5. Both clear on reset.
